// File: rtl/muldiv_seq_unit.sv
// Sequential multiply/divide engine: one bit per clock, producing a packed {Hi,Lo} result.
// Signed operands run on magnitudes, and the signs are fixed up on the edge that enters DONE.
module muldiv_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     opA,
  input  logic [WIDTH-1:0]     opB,
  output logic                 busy,
  output logic                 done,
  output logic                 div0,
  output logic [2*WIDTH-1:0]   mutiAns
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;
  state_t state, stateNext;

  logic [1:0]         opReg;
  logic [WIDTH-1:0]   aReg, magA, magB, aAbs, bAbs, quo, rem;
  logic               negRes, negRem, isDiv, isSigned;
  logic [2*WIDTH-1:0] acc, accNext, resNext;
  logic [WIDTH:0]     mulSum, remShift, remDiff;
  logic [CW-1:0]      cnt;

  assign isSigned = opReg[1];
  assign isDiv    = opReg[0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) stateNext = LOAD;
      end
      LOAD: stateNext = CALC;
      CALC: if (cnt == '0) stateNext = DONE;
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // magA/magB hold the raw operands until LOAD converts them to magnitudes
  always_comb begin
    aAbs     = (isSigned && magA[WIDTH-1]) ? -magA : magA;
    bAbs     = (isSigned && magB[WIDTH-1]) ? -magB : magB;
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magA} : '0);
    remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    remDiff  = remShift - {1'b0, magB};
    if (!isDiv)
      accNext = {mulSum, acc[WIDTH-1:1]};
    else if (remDiff[WIDTH])
      accNext = {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      accNext = {remDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    quo = negRes ? -accNext[WIDTH-1:0] : accNext[WIDTH-1:0];
    rem = negRem ? -accNext[2*WIDTH-1:WIDTH] : accNext[2*WIDTH-1:WIDTH];
    if (!isDiv)
      resNext = negRes ? -accNext : accNext;
    else if (magB == '0)
      resNext = {aReg, {WIDTH{1'b1}}};
    else
      resNext = {rem, quo};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opReg   <= '0;
      aReg    <= '0;
      magA    <= '0;
      magB    <= '0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      div0    <= 1'b0;
      mutiAns <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          opReg <= op;
          aReg  <= opA;
          magA  <= opA;
          magB  <= opB;
        end
        LOAD: begin
          magA   <= aAbs;
          magB   <= bAbs;
          negRes <= isSigned & (magA[WIDTH-1] ^ magB[WIDTH-1]);
          negRem <= isSigned & magA[WIDTH-1];
          acc    <= isDiv ? {{WIDTH{1'b0}}, aAbs} : {{WIDTH{1'b0}}, bAbs};
          cnt    <= CW'(WIDTH - 1);
        end
        CALC: begin
          acc <= accNext;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            mutiAns <= resNext;
            div0    <= isDiv && (magB == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Scoreboard bench for muldiv_seq_unit: expected {div0,Hi,Lo} is queued at issue and compared when done pulses.
module tb_muldiv_seq_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [1:0]    op;
  logic [W-1:0]  opA, opB;
  logic          busy, done, div0;
  logic [2*W-1:0] mutiAns;

  int errors = 0;
  int checks = 0;
  logic [2*W:0] sbq[$];

  muldiv_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .div0(div0), .mutiAns(mutiAns)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p, q64, r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      2'b10: begin p = 64'(sa * sb); return {1'b0, p}; end
      2'b01: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        q64 = 64'(q); r64 = 64'(r);
        return {1'b0, r64[31:0], q64[31:0]};
      end
    endcase
  endfunction

  // Issues one op, scrambles the inputs after acceptance, and observes until busy drops.
  task automatic runOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int pulseAt, output logic [2*W-1:0] ans, output logic d0,
                       output int doneIdx, output int busyN, output int doneN);
    @(negedge clk);
    start = 1'b1; op = o; opA = a; opB = b;
    sbq.push_back(model(o, a, b));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; opA = $urandom; opB = $urandom; op = 2'($urandom);
    ans = '0; d0 = 1'b0; doneIdx = -1; busyN = 0; doneN = 0;
    for (int i = 1; i <= 100; i++) begin
      if (busy) busyN++;
      if (done) begin doneN++; doneIdx = i; ans = mutiAns; d0 = div0; end
      if (!busy) break;
      start = (i == pulseAt);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; opA = '0; opB = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL reset_div0 got %b want 0", div0); end
    checks++; if (mutiAns !== '0) begin errors++; $display("FAIL reset_ans got %h want 0", mutiAns); end
    reset = 1'b0;
  endtask

  task automatic test_ops(input string name, input logic [1:0] o[], input logic [W-1:0] a[],
                          input logic [W-1:0] b[]);
    logic [2*W-1:0] ans; logic d0; int di, bn, dn; logic [2*W:0] exp;
    for (int k = 0; k < o.size(); k++) begin
      runOp(o[k], a[k], b[k], 0, ans, d0, di, bn, dn);
      exp = sbq.pop_front();
      checks++; if (ans !== exp[2*W-1:0]) begin errors++;
        $display("FAIL %s_ans[%0d] got %h want %h", name, k, ans, exp[2*W-1:0]); end
      checks++; if (d0 !== exp[2*W]) begin errors++;
        $display("FAIL %s_div0[%0d] got %b want %b", name, k, d0, exp[2*W]); end
      checks++; if (di != W + 2 || dn != 1) begin errors++;
        $display("FAIL %s_latency[%0d] got idx=%0d pulses=%0d want idx=%0d pulses=1", name, k, di, dn, W + 2); end
      checks++; if (bn != W + 2) begin errors++;
        $display("FAIL %s_busy[%0d] got %0d want %0d", name, k, bn, W + 2); end
    end
  endtask

  task automatic test_mul();
    test_ops("mul", '{2'b00, 2'b10, 2'b00, 2'b10, 2'b10},
             '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'h8000_0000, 32'h8000_0000},
             '{32'hFFFF_FFFF, 32'h3, 32'h1234_5678, 32'h8000_0000, 32'h7FFF_FFFF});
  endtask

  task automatic test_div();
    test_ops("div", '{2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01},
             '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'd5, 32'd2, 32'hFFFF_FF00, 32'd3},
             '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd3, 32'd0, 32'hFFFF_FFFF});
  endtask

  task automatic test_random();
    logic [1:0] o[]; logic [W-1:0] a[], b[];
    o = new[8]; a = new[8]; b = new[8];
    for (int k = 0; k < 8; k++) begin
      o[k] = 2'(k); a[k] = $urandom; b[k] = (k == 5) ? 32'($urandom_range(1, 9)) : $urandom;
    end
    test_ops("rand", o, a, b);
  endtask

  task automatic test_busy_start();
    logic [2*W-1:0] ans; logic d0; int di, bn, dn; logic [2*W:0] exp; int bad;
    runOp(2'b11, 32'hFFFF_FC18, 32'd37, 10, ans, d0, di, bn, dn);
    exp = sbq.pop_front();
    checks++; if (ans !== exp[2*W-1:0]) begin errors++;
      $display("FAIL busy_start_ans got %h want %h", ans, exp[2*W-1:0]); end
    checks++; if (dn != 1 || bn != W + 2) begin errors++;
      $display("FAIL busy_start_pulses got done=%0d busy=%0d want 1/%0d", dn, bn, W + 2); end
    bad = 0;
    opA = 32'h5; opB = 32'h9; op = 2'b00;
    repeat (20) begin
      @(negedge clk);
      if (mutiAns !== exp[2*W-1:0] || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid();
    int dn;
    @(negedge clk);
    start = 1'b1; op = 2'b11; opA = 32'hFFFF_FF9C; opB = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    checks++; if (busy !== 1'b1 || mutiAns === '0) begin errors++;
      $display("FAIL mid_pre got busy=%b ans=%h want busy=1 ans!=0", busy, mutiAns); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL mid_reset_ctl got busy=%b done=%b want 0/0", busy, done); end
    checks++; if (mutiAns !== '0 || div0 !== 1'b0) begin errors++;
      $display("FAIL mid_reset_ans got %h div0=%b want 0/0", mutiAns, div0); end
    dn = 0;
    repeat (40) begin @(negedge clk); if (done) dn++; end
    checks++; if (dn != 0) begin errors++;
      $display("FAIL mid_no_done got %0d pulses want 0", dn); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_random();
    test_busy_start();
    test_reset_mid();
    checks++; if (sbq.size() != 0) begin errors++;
      $display("FAIL scoreboard_left got %0d want 0", sbq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
